// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO.
//   DATA_W_DEF / DEPTH_DEF : default data width and entry count
//   clog2()                : ceiling log2, usable in constant expressions
package fifo_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 16;

    // Ceiling log2; returns 0 for inputs of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        while (remain > 0) begin
            result = result + 1;
            remain = remain >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: DATA_W x DEPTH array, one synchronous write port and one
// asynchronous read port. The array has no reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int AW     = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    // The head word must be visible in the same cycle it becomes the head,
    // so the read side is deliberately unregistered.
    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered status flags,
// occupancy level and sticky overflow/underflow errors.
//   clk          : clock, all state on rising edge
//   rst_n        : synchronous active-low reset (highest priority)
//   flush        : synchronous empty request (pointers to zero)
//   w_en, data_w : write request and data
//   r_en         : read request (pop)
//   data_r       : head-of-queue word, zero while empty
//   clr_err      : clears sticky overflow/underflow
//   empty, full, almost_empty, almost_full : registered status
//   level        : current occupancy (0..DEPTH)
//   overflow, underflow : sticky error flags
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int AF_LVL = DEPTH - 2,
    parameter int AE_LVL = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  w_en,
    input  logic [DATA_W-1:0]     data_w,
    input  logic                  r_en,
    output logic [DATA_W-1:0]     data_r,
    input  logic                  clr_err,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [clog2(DEPTH):0] level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int AW = clog2(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [PW-1:0] DEPTH_L  = PW'(DEPTH);
    localparam logic [PW-1:0] AF_LVL_L = PW'(AF_LVL);
    localparam logic [PW-1:0] AE_LVL_L = PW'(AE_LVL);

    // Pointers carry one extra bit so full (level==DEPTH) and empty
    // (level==0) are distinguishable with a plain subtraction.
    logic [PW-1:0]     wptr_reg, wptr_next;
    logic [PW-1:0]     rptr_reg, rptr_next;
    logic [PW-1:0]     level_reg, level_next;
    logic              empty_reg, empty_next;
    logic              full_reg, full_next;
    logic              almost_empty_reg, almost_empty_next;
    logic              almost_full_reg, almost_full_next;
    logic              overflow_reg, overflow_next;
    logic              underflow_reg, underflow_next;

    logic              wr_ok;
    logic              rd_ok;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    // Acceptance uses the registered flags only, so a read never frees
    // room for a same-cycle write and a write never feeds a same-cycle read.
    assign wr_ok  = w_en && !full_reg;
    assign rd_ok  = r_en && !empty_reg;
    assign mem_we = wr_ok && !flush;

    always_comb begin
        wptr_next = wptr_reg;
        rptr_next = rptr_reg;
        if (flush) begin
            wptr_next = '0;
            rptr_next = '0;
        end else begin
            if (wr_ok) begin
                wptr_next = wptr_reg + PW'(1);
            end
            if (rd_ok) begin
                rptr_next = rptr_reg + PW'(1);
            end
        end

        level_next        = wptr_next - rptr_next;
        empty_next        = (level_next == '0);
        full_next         = (level_next == DEPTH_L);
        almost_full_next  = (level_next >= AF_LVL_L);
        almost_empty_next = (level_next <= AE_LVL_L);

        // A setting condition wins over a same-cycle clear.
        overflow_next  = (overflow_reg && !clr_err) || (w_en && full_reg);
        underflow_next = (underflow_reg && !clr_err) || (r_en && empty_reg);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_reg         <= '0;
            rptr_reg         <= '0;
            level_reg        <= '0;
            empty_reg        <= 1'b1;
            full_reg         <= 1'b0;
            almost_empty_reg <= 1'b1;
            almost_full_reg  <= 1'b0;
            overflow_reg     <= 1'b0;
            underflow_reg    <= 1'b0;
        end else begin
            wptr_reg         <= wptr_next;
            rptr_reg         <= rptr_next;
            level_reg        <= level_next;
            empty_reg        <= empty_next;
            full_reg         <= full_next;
            almost_empty_reg <= almost_empty_next;
            almost_full_reg  <= almost_full_next;
            overflow_reg     <= overflow_next;
            underflow_reg    <= underflow_next;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wptr_reg[AW-1:0]),
        .wdata (data_w),
        .raddr (rptr_reg[AW-1:0]),
        .rdata (mem_rdata)
    );

    // Stale storage is never exposed: the head reads as zero while empty.
    assign data_r       = empty_reg ? '0 : mem_rdata;
    assign empty        = empty_reg;
    assign full         = full_reg;
    assign almost_empty = almost_empty_reg;
    assign almost_full  = almost_full_reg;
    assign level        = level_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (DATA_W=32, DEPTH=16).
module tb_sync_fifo;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        w_en;
    logic [31:0] data_w;
    logic        r_en;
    logic [31:0] data_r;
    logic        clr_err;
    logic        empty;
    logic        full;
    logic        almost_empty;
    logic        almost_full;
    logic [4:0]  level;
    logic        overflow;
    logic        underflow;

    int n_vec;
    int n_err;

    sync_fifo #(
        .DATA_W (32),
        .DEPTH  (16),
        .AF_LVL (14),
        .AE_LVL (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .w_en         (w_en),
        .data_w       (data_w),
        .r_en         (r_en),
        .data_r       (data_r),
        .clr_err      (clr_err),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .level        (level),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, obs);
        end
    endtask

    // Advance one edge; outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".level"}, 64'(level), 64'd0);
        check({tag, ".empty"}, 64'(empty), 64'd1);
        check({tag, ".aempty"}, 64'(almost_empty), 64'd1);
        check({tag, ".full"}, 64'(full), 64'd0);
        check({tag, ".afull"}, 64'(almost_full), 64'd0);
        check({tag, ".ovf"}, 64'(overflow), 64'd0);
        check({tag, ".udf"}, 64'(underflow), 64'd0);
        check({tag, ".data_r"}, 64'(data_r), 64'd0);
    endtask

    task automatic push_n(input int n, input logic [31:0] base);
        w_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            data_w = base + 32'(i);
            step();
        end
        w_en = 1'b0;
    endtask

    logic [31:0] model_q[$];

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        flush   = 1'b0;
        w_en    = 1'b0;
        r_en    = 1'b0;
        clr_err = 1'b0;
        data_w  = '0;
        #1;
        step();
        step();
        rst_n = 1'b1;
        check_reset_state("reset");

        // Fill 0x11..0x20 and watch the thresholds move.
        w_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            data_w = 32'h11 + 32'(i);
            step();
            check($sformatf("fill%0d.level", i), 64'(level), 64'(i + 1));
            check($sformatf("fill%0d.afull", i), 64'(almost_full), 64'((i + 1) >= 14));
            check($sformatf("fill%0d.full", i), 64'(full), 64'((i + 1) == 16));
            check($sformatf("fill%0d.aempty", i), 64'(almost_empty), 64'((i + 1) <= 2));
            check($sformatf("fill%0d.head", i), 64'(data_r), 64'h11);
        end

        // Write into a full FIFO is dropped and raises overflow.
        data_w = 32'hDEAD;
        step();
        check("ovf.set", 64'(overflow), 64'd1);
        check("ovf.level", 64'(level), 64'd16);
        w_en = 1'b0;
        step();
        check("ovf.sticky", 64'(overflow), 64'd1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("ovf.clr", 64'(overflow), 64'd0);

        // Full with read+write: read accepted, write rejected.
        w_en   = 1'b1;
        r_en   = 1'b1;
        data_w = 32'hBEEF;
        step();
        w_en = 1'b0;
        r_en = 1'b0;
        check("fullrw.level", 64'(level), 64'd15);
        check("fullrw.ovf", 64'(overflow), 64'd1);
        check("fullrw.head", 64'(data_r), 64'h12);

        // Drain 0x12..0x20; neither 0xDEAD nor 0xBEEF may appear.
        r_en = 1'b1;
        for (int i = 0; i < 15; i++) begin
            check($sformatf("drain%0d.data", i), 64'(data_r), 64'h12 + 64'(i));
            step();
            check($sformatf("drain%0d.level", i), 64'(level), 64'(14 - i));
        end
        check("drain.empty", 64'(empty), 64'd1);
        check("drain.data_r", 64'(data_r), 64'd0);

        // r_en still high on an empty FIFO: underflow.
        step();
        r_en = 1'b0;
        check("udf.set", 64'(underflow), 64'd1);
        check("udf.level", 64'(level), 64'd0);
        check("udf.data_r", 64'(data_r), 64'd0);
        r_en    = 1'b1;
        clr_err = 1'b1;
        step();
        check("udf.setwins", 64'(underflow), 64'd1);
        r_en = 1'b0;
        step();
        clr_err = 1'b0;
        check("udf.clr", 64'(underflow), 64'd0);
        check("udf.ovfclr", 64'(overflow), 64'd0);

        // Empty with read+write: write accepted, read rejected.
        w_en   = 1'b1;
        r_en   = 1'b1;
        data_w = 32'h55;
        step();
        w_en = 1'b0;
        r_en = 1'b0;
        check("emptyrw.level", 64'(level), 64'd1);
        check("emptyrw.udf", 64'(underflow), 64'd1);
        check("emptyrw.head", 64'(data_r), 64'h55);
        clr_err = 1'b1;
        r_en    = 1'b1;
        step();
        clr_err = 1'b0;
        r_en    = 1'b0;
        check("emptyrw.pop", 64'(empty), 64'd1);
        check("emptyrw.udfclr", 64'(underflow), 64'd0);

        // Level 8, then 40 cycles of simultaneous read+write across wrap.
        model_q.delete();
        push_n(8, 32'h100);
        for (int i = 0; i < 8; i++) model_q.push_back(32'h100 + 32'(i));
        check("steady.level0", 64'(level), 64'd8);
        w_en = 1'b1;
        r_en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            data_w = 32'h108 + 32'(k);
            check($sformatf("steady%0d.data", k), 64'(data_r), 64'(model_q[0]));
            step();
            void'(model_q.pop_front());
            model_q.push_back(32'h108 + 32'(k));
            check($sformatf("steady%0d.level", k), 64'(level), 64'd8);
        end
        w_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("sdrain%0d.data", i), 64'(data_r), 64'h128 + 64'(i));
            step();
        end
        r_en = 1'b0;
        check("sdrain.empty", 64'(empty), 64'd1);

        // Level 5, flush with a concurrent write.
        push_n(5, 32'h200);
        check("flush.level5", 64'(level), 64'd5);
        flush  = 1'b1;
        w_en   = 1'b1;
        data_w = 32'hBAD;
        step();
        flush = 1'b0;
        w_en  = 1'b0;
        check("flush.level", 64'(level), 64'd0);
        check("flush.empty", 64'(empty), 64'd1);
        check("flush.data_r", 64'(data_r), 64'd0);
        push_n(1, 32'h300);
        check("flush.after", 64'(data_r), 64'h300);
        check("flush.alevel", 64'(level), 64'd1);

        // Level 10, reset with a concurrent write.
        push_n(9, 32'h400);
        check("rst.level10", 64'(level), 64'd10);
        rst_n  = 1'b0;
        w_en   = 1'b1;
        data_w = 32'h999;
        step();
        check_reset_state("midrst");
        rst_n = 1'b1;
        w_en  = 1'b0;
        step();
        check("midrst.after.level", 64'(level), 64'd0);
        check("midrst.after.empty", 64'(empty), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
